// File: rtl/rhd_convert_sequencer.sv
// rhd_convert_sequencer: builds the CONVERT(0..NUM_CH-1)+AUX command stream for rhd_spi_master
// and re-tags each result to the command issued two slots earlier. Define RHD_SEQ_TIMESTAMP_EN to add sample_ts.
module rhd_convert_sequencer #(
    parameter int NUM_CH  = 32,
    parameter int CMD_GAP = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [15:0] aux_cmd,
    input  logic        aux_req,
    output logic        aux_ack,
    output logic        spi_start,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [31:0] spi_data,
    output logic        sample_valid,
    output logic [31:0] sample_data,
    output logic [5:0]  sample_ch,
    output logic        sample_aux,
    output logic        frame_start
`ifdef RHD_SEQ_TIMESTAMP_EN
    ,
    output logic [31:0] sample_ts
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    localparam logic [5:0]  AUX_SLOT  = 6'(NUM_CH);
    localparam logic [7:0]  GAP_LAST  = 8'(CMD_GAP);
    localparam logic [15:0] AUX_DUMMY = 16'hFF00;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [5:0]  slot;
    logic [7:0]  gap_cnt;
    logic [1:0]  primed;
    logic [6:0]  cur_tag;
    logic [6:0]  tag_pipe [2];

    logic        do_issue;
    logic [5:0]  issue_slot;
    logic        issue_aux;
    logic        aux_take;
    logic [15:0] issue_cmd;
    logic        take_done;
    logic        frame_end;

    assign frame_end = (slot == AUX_SLOT);
    assign take_done = (state == S_WAIT_DONE) && spi_done;

    // Issue decisions happen only in IDLE and at the last GAP cycle; enable is looked at only at frame end.
    always_comb begin
        state_nxt  = state;
        do_issue   = 1'b0;
        issue_slot = 6'd0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    do_issue  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (spi_done) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (frame_end && !enable) begin
                        state_nxt = S_IDLE;
                    end else begin
                        do_issue   = 1'b1;
                        issue_slot = frame_end ? 6'd0 : slot + 6'd1;
                        state_nxt  = S_ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign issue_aux = do_issue && (issue_slot == AUX_SLOT);
    assign aux_take  = issue_aux && aux_req;

    always_comb begin
        issue_cmd = {2'b00, issue_slot, 8'h00};
        if (issue_aux) begin
            issue_cmd = aux_req ? aux_cmd : AUX_DUMMY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            slot        <= 6'd0;
            gap_cnt     <= 8'd0;
            spi_start   <= 1'b0;
            spi_cmd     <= 16'd0;
            aux_ack     <= 1'b0;
            frame_start <= 1'b0;
            cur_tag     <= 7'd0;
        end else begin
            state       <= state_nxt;
            spi_start   <= do_issue;
            aux_ack     <= aux_take;
            frame_start <= do_issue && (issue_slot == 6'd0);
            if (do_issue) begin
                slot    <= issue_slot;
                spi_cmd <= issue_cmd;
                cur_tag <= {issue_aux, issue_slot};
            end
            if (state == S_WAIT_DONE) begin
                gap_cnt <= 8'd0;
            end else if ((state == S_GAP) && (gap_cnt != GAP_LAST)) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

    // The two results after leaving IDLE have no real command behind them, so primed gates sample_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            primed       <= 2'd0;
            tag_pipe[0]  <= 7'd0;
            tag_pipe[1]  <= 7'd0;
            sample_valid <= 1'b0;
            sample_data  <= 32'd0;
            sample_ch    <= 6'd0;
            sample_aux   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if ((state == S_IDLE) && enable) begin
                primed <= 2'd0;
            end
            if (take_done) begin
                sample_data                <= spi_data;
                {sample_aux, sample_ch}    <= tag_pipe[1];
                tag_pipe[1]                <= tag_pipe[0];
                tag_pipe[0]                <= cur_tag;
                if (primed == 2'd2) begin
                    sample_valid <= 1'b1;
                end else begin
                    primed <= primed + 2'd1;
                end
            end
        end
    end

`ifdef RHD_SEQ_TIMESTAMP_EN
    logic [31:0] frame_cnt;
    logic [31:0] cur_ts;
    logic [31:0] ts_pipe [2];

    // Frame number travels alongside the channel tag; only rstn clears the counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt  <= 32'd0;
            cur_ts     <= 32'd0;
            ts_pipe[0] <= 32'd0;
            ts_pipe[1] <= 32'd0;
            sample_ts  <= 32'd0;
        end else begin
            if (do_issue && (issue_slot == 6'd0)) begin
                frame_cnt <= frame_cnt + 32'd1;
                cur_ts    <= frame_cnt;
            end
            if (take_done) begin
                sample_ts  <= ts_pipe[1];
                ts_pipe[1] <= ts_pipe[0];
                ts_pipe[0] <= cur_ts;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rhd_convert_sequencer.sv
// tb_rhd_convert_sequencer: randomized bench with a modelled SPI master and an index-based
// command/tag reference model; a second instance runs with CMD_GAP=0.
module tb_rhd_convert_sequencer;

    localparam int NUM_CH = 4;
    localparam int FRAME  = NUM_CH + 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [15:0] aux_cmd;
    logic        aux_req;
    logic        aux_ack;
    logic        spi_start;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [31:0] spi_data;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic [5:0]  sample_ch;
    logic        sample_aux;
    logic        frame_start;

    logic        enable_g0;
    logic [15:0] aux_cmd_g0;
    logic        aux_req_g0;
    logic        aux_ack_g0;
    logic        spi_start_g0;
    logic [15:0] spi_cmd_g0;
    logic        spi_done_g0;
    logic [31:0] spi_data_g0;
    logic        sample_valid_g0;
    logic [31:0] sample_data_g0;
    logic [5:0]  sample_ch_g0;
    logic        sample_aux_g0;
    logic        frame_start_g0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] st_cmd [$];
    int          st_cyc [$];
    bit          st_fs  [$];
    bit          st_ack [$];
    logic [31:0] dn_data [$];
    int          dn_cyc  [$];
    logic [31:0] sm_data [$];
    logic [5:0]  sm_ch   [$];
    bit          sm_aux  [$];
    int          sm_cyc  [$];
    int          g0_start_cyc [$];
    int          g0_done_cyc  [$];

    int          pend         = 0;
    int          pend0        = 0;
    int          fixed_lat    = 20;
    int          last_evt     = 0;
    int          ack_count    = 0;
    int          aux_raise_at = -1;
    logic [15:0] aux_val_pending = 16'h0;

    rhd_convert_sequencer #(.NUM_CH(NUM_CH), .CMD_GAP(4)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .aux_cmd(aux_cmd), .aux_req(aux_req),
        .aux_ack(aux_ack), .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_done(spi_done),
        .spi_data(spi_data), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ch(sample_ch), .sample_aux(sample_aux), .frame_start(frame_start)
    );

    rhd_convert_sequencer #(.NUM_CH(NUM_CH), .CMD_GAP(0)) dut_g0 (
        .clk(clk), .rstn(rstn), .enable(enable_g0), .aux_cmd(aux_cmd_g0), .aux_req(aux_req_g0),
        .aux_ack(aux_ack_g0), .spi_start(spi_start_g0), .spi_cmd(spi_cmd_g0), .spi_done(spi_done_g0),
        .spi_data(spi_data_g0), .sample_valid(sample_valid_g0), .sample_data(sample_data_g0),
        .sample_ch(sample_ch_g0), .sample_aux(sample_aux_g0), .frame_start(frame_start_g0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model, AUX requester and output logger for the main instance; everything acts on negedges.
    initial begin : master_model
        spi_done = 1'b0;
        spi_data = 32'h0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (!rstn) begin
                pend = 0;
            end else begin
                if (aux_ack) begin
                    aux_req = 1'b0;
                    ack_count++;
                end
                if (sample_valid) begin
                    sm_data.push_back(sample_data);
                    sm_ch.push_back(sample_ch);
                    sm_aux.push_back(sample_aux);
                    sm_cyc.push_back(cyc);
                    last_evt = cyc;
                end
                if (spi_start) begin
                    st_cmd.push_back(spi_cmd);
                    st_cyc.push_back(cyc);
                    st_fs.push_back(frame_start);
                    st_ack.push_back(aux_ack);
                    pend     = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(24, 2));
                    last_evt = cyc;
                    if (st_cmd.size() - 1 == aux_raise_at) begin
                        aux_cmd = aux_val_pending;
                        aux_req = 1'b1;
                    end
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        spi_done = 1'b1;
                        spi_data = $urandom;
                        dn_data.push_back(spi_data);
                        dn_cyc.push_back(cyc);
                        last_evt = cyc;
                    end
                end
            end
        end
    end

    initial begin : master_model_g0
        spi_done_g0 = 1'b0;
        spi_data_g0 = 32'h0;
        forever begin
            @(negedge clk);
            spi_done_g0 = 1'b0;
            if (!rstn) begin
                pend0 = 0;
            end else if (spi_start_g0) begin
                g0_start_cyc.push_back(cyc);
                pend0 = 3;
            end else if (pend0 > 0) begin
                pend0--;
                if (pend0 == 0) begin
                    spi_done_g0 = 1'b1;
                    spi_data_g0 = $urandom;
                    g0_done_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: command for the idx-th transaction since leaving IDLE.
    function automatic logic [15:0] model_cmd(input int idx, input int aux_idx, input logic [15:0] aux_val);
        int s;
        s = idx % FRAME;
        if (s == NUM_CH) return (idx == aux_idx) ? aux_val : 16'hFF00;
        return 16'(s * 256);
    endfunction

    task automatic clear_logs();
        st_cmd.delete(); st_cyc.delete(); st_fs.delete(); st_ack.delete();
        dn_data.delete(); dn_cyc.delete();
        sm_data.delete(); sm_ch.delete(); sm_aux.delete(); sm_cyc.delete();
        ack_count = 0;
    endtask

    task automatic wait_quiet(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); #1;
            if ((pend == 0) && (cyc - last_evt > 50)) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_and_stop(input int stop_idx, output bit to);
        to = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); #1;
            if (st_cmd.size() > stop_idx) begin
                to = 1'b0;
                break;
            end
        end
        enable = 1'b0;
        if (!to) wait_quiet(to);
    endtask

    task automatic test_reset();
        logic [57:0] obs;
        enable = 1'b0; aux_req = 1'b0; aux_cmd = 16'h0;
        enable_g0 = 1'b0; aux_req_g0 = 1'b0; aux_cmd_g0 = 16'h0;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        #1;
        obs = {aux_ack, spi_start, spi_cmd, sample_valid, sample_data, sample_ch, sample_aux, frame_start};
        n_tests++;
        if (obs !== 58'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        obs = {aux_ack, spi_start, spi_cmd, sample_valid, sample_data, sample_ch, sample_aux, frame_start};
        n_tests++;
        if (obs !== 58'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_continuous(input int lat, input int stop_idx, input int aux_at, input logic [15:0] aux_val);
        bit to;
        int total, a, n, ns;
        clear_logs();
        aux_req = 1'b0;
        fixed_lat = lat;
        aux_raise_at = aux_at;
        aux_val_pending = aux_val;
        total = (stop_idx / FRAME + 1) * FRAME;
        a = -1;
        if (aux_at >= 0) begin
            a = aux_at + 1;
            while (a % FRAME != NUM_CH) a++;
        end
        run_and_stop(stop_idx, to);
        aux_raise_at = -1;
        n_tests++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL run_timeout: got timeout=%0d expected 0", to);
        end
        n_tests++;
        if (st_cmd.size() != total) begin
            n_fail++;
            $display("[TB] FAIL start_count: got %0d expected %0d", st_cmd.size(), total);
        end
        n = (st_cmd.size() < total) ? st_cmd.size() : total;
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (st_cmd[i] !== model_cmd(i, a, aux_val)) begin
                n_fail++;
                $display("[TB] FAIL spi_cmd[%0d]: got %h expected %h", i, st_cmd[i], model_cmd(i, a, aux_val));
            end
            n_tests++;
            if (st_fs[i] !== (i % FRAME == 0)) begin
                n_fail++;
                $display("[TB] FAIL frame_start[%0d]: got %0d expected %0d", i, st_fs[i], (i % FRAME == 0));
            end
            n_tests++;
            if (st_ack[i] !== (i == a)) begin
                n_fail++;
                $display("[TB] FAIL aux_ack[%0d]: got %0d expected %0d", i, st_ack[i], (i == a));
            end
            if ((i > 0) && (i <= dn_cyc.size())) begin
                n_tests++;
                if (st_cyc[i] - dn_cyc[i-1] != 6) begin
                    n_fail++;
                    $display("[TB] FAIL gap4_spacing[%0d]: got %0d expected 6", i, st_cyc[i] - dn_cyc[i-1]);
                end
            end
        end
        n_tests++;
        if (ack_count != ((a >= 0) ? 1 : 0)) begin
            n_fail++;
            $display("[TB] FAIL aux_ack_count: got %0d expected %0d", ack_count, (a >= 0) ? 1 : 0);
        end
        n_tests++;
        if (sm_data.size() != total - 2) begin
            n_fail++;
            $display("[TB] FAIL sample_count: got %0d expected %0d", sm_data.size(), total - 2);
        end
        ns = sm_data.size();
        if (ns > dn_data.size() - 2) ns = dn_data.size() - 2;
        for (int j = 0; j < ns; j++) begin
            n_tests++;
            if (sm_data[j] !== dn_data[j+2]) begin
                n_fail++;
                $display("[TB] FAIL sample_data[%0d]: got %h expected %h", j, sm_data[j], dn_data[j+2]);
            end
            n_tests++;
            if ((sm_ch[j] !== 6'(j % FRAME)) || (sm_aux[j] !== (j % FRAME == NUM_CH))) begin
                n_fail++;
                $display("[TB] FAIL sample_tag[%0d]: got ch=%0d aux=%0d expected ch=%0d aux=%0d",
                         j, sm_ch[j], sm_aux[j], j % FRAME, (j % FRAME == NUM_CH));
            end
            n_tests++;
            if (sm_cyc[j] - dn_cyc[j+2] != 1) begin
                n_fail++;
                $display("[TB] FAIL sample_latency[%0d]: got %0d expected 1", j, sm_cyc[j] - dn_cyc[j+2]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int starts;
        test_continuous(0, 1, -1, 16'h0);
        starts = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi_start) starts++;
        end
        n_tests++;
        if (starts != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_drop: got %0d starts expected 0", starts);
        end
    endtask

    task automatic test_reset_mid();
        logic [57:0] obs;
        bit to;
        clear_logs();
        fixed_lat = 20;
        enable = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (st_cmd.size() > 2) begin
                to = 1'b0;
                break;
            end
        end
        n_tests++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_timeout: got timeout=%0d expected 0", to);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (spi_cmd !== model_cmd(2, -1, 16'h0)) begin
            n_fail++;
            $display("[TB] FAIL cmd_before_reset: got %h expected %h", spi_cmd, model_cmd(2, -1, 16'h0));
        end
        #1 rstn = 1'b0;
        enable = 1'b0;
        #1;
        obs = {aux_ack, spi_start, spi_cmd, sample_valid, sample_data, sample_ch, sample_aux, frame_start};
        n_tests++;
        if (obs !== 58'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0", obs);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (sm_data.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_samples: got %0d expected 0", sm_data.size());
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        test_continuous(0, FRAME + 2, -1, 16'h0);
    endtask

    task automatic test_gap0();
        bit to;
        g0_start_cyc.delete();
        g0_done_cyc.delete();
        enable_g0 = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (g0_start_cyc.size() >= 8) begin
                to = 1'b0;
                break;
            end
        end
        enable_g0 = 1'b0;
        repeat (60) @(negedge clk);
        n_tests++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gap0_timeout: got timeout=%0d expected 0", to);
        end
        for (int i = 1; i < 8 && i < g0_start_cyc.size() && i <= g0_done_cyc.size(); i++) begin
            n_tests++;
            if (g0_start_cyc[i] - g0_done_cyc[i-1] != 2) begin
                n_fail++;
                $display("[TB] FAIL gap0_spacing[%0d]: got %0d expected 2", i, g0_start_cyc[i] - g0_done_cyc[i-1]);
            end
        end
        n_tests++;
        if (g0_start_cyc.size() != 10) begin
            n_fail++;
            $display("[TB] FAIL gap0_frame_end: got %0d starts expected 10", g0_start_cyc.size());
        end
    endtask

    initial begin : main
        int stop, at;
        test_reset();
        test_continuous(20, FRAME, -1, 16'h0);
        test_continuous(20, FRAME, 1, 16'h8035);
        for (int k = 0; k < 4; k++) begin
            stop = int'($urandom_range(3 * FRAME - 1, 0));
            at = -1;
            if ($urandom_range(1, 0) == 1) begin
                at = (stop / FRAME) * FRAME + int'($urandom_range(NUM_CH - 1, 0));
            end
            test_continuous(0, stop, at, 16'($urandom));
        end
        test_enable_drop();
        test_reset_mid();
        test_gap0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
